// File: rtl/mat_pkg.sv
// Shared constants, state/error encodings and dimension check for the matrix
// write sequencer.
package mat_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int MAX_SIZE       = 5;
  localparam int MATRIX_NUM     = 8;
  localparam int FIRST_FREE_IDX = 4;
  localparam int MEM_DEPTH      = 25;
  localparam int MATRIX_IDX_W   = 3;
  localparam int DIM_W          = 3;
  localparam int CNT_W          = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LOAD,
    ST_WRITE,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DIM     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_CANCEL  = 2'd3
  } err_code_t;

  function automatic logic dims_bad(input logic [DIM_W-1:0] r,
                                    input logic [DIM_W-1:0] c,
                                    input logic [DIM_W-1:0] max_dim);
    return (r == '0) || (c == '0) || (r > max_dim) || (c > max_dim);
  endfunction

endpackage

// File: rtl/mat_idx_alloc.sv
// Round-robin allocator for storage slots FIRST_IDX..LAST_IDX; steps once per
// advance pulse and wraps back to FIRST_IDX.
module mat_idx_alloc #(
  parameter int IDX_W     = mat_pkg::MATRIX_IDX_W,
  parameter int FIRST_IDX = mat_pkg::FIRST_FREE_IDX,
  parameter int LAST_IDX  = mat_pkg::MATRIX_NUM - 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             advance_i,
  output logic [IDX_W-1:0] idx_o
);
  import mat_pkg::*;

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (advance_i) begin
      if (idx_q == IDX_W'(LAST_IDX)) idx_d = IDX_W'(FIRST_IDX);
      else                           idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) idx_q <= IDX_W'(FIRST_IDX);
    else       idx_q <= idx_d;
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/matrix_write_ctrl.sv
// Collects a row*col matrix element-by-element and writes it to
// multi_matrix_storage in a single wr_en cycle at a round-robin slot.
module matrix_write_ctrl #(
  parameter int DATA_WIDTH     = mat_pkg::DATA_WIDTH,
  parameter int MAX_SIZE       = mat_pkg::MAX_SIZE,
  parameter int MATRIX_NUM     = mat_pkg::MATRIX_NUM,
  parameter int FIRST_FREE_IDX = mat_pkg::FIRST_FREE_IDX,
  parameter int TIMEOUT_CYC    = 1000000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [2:0]                            dim_row,
  input  logic [2:0]                            dim_col,
  input  logic                                  cancel,
  input  logic                                  elem_valid,
  input  logic [DATA_WIDTH-1:0]                 elem_data,
  output logic                                  elem_ready,
  output logic                                  wr_en,
  output logic [2:0]                            target_idx,
  output logic [2:0]                            write_row,
  output logic [2:0]                            write_col,
  output logic [mat_pkg::MEM_DEPTH*DATA_WIDTH-1:0] data_flat,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic [1:0]                            err_code
);
  import mat_pkg::*;

  localparam int FW = MEM_DEPTH * DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t                  state_q;
  err_code_t               err_code_q;
  logic [DIM_W-1:0]        row_q, col_q, wrow_q, wcol_q;
  logic [CNT_W-1:0]        total_q, cnt_q;
  logic [TW-1:0]           idle_q;
  logic [FW-1:0]           buf_q, buf_wr, flat_q;
  logic [MATRIX_IDX_W-1:0] tgt_q, next_idx;
  logic                    wr_en_q, done_q, err_q, advance;

  assign advance = (state_q == ST_FIN);

  mat_idx_alloc #(
    .IDX_W    (MATRIX_IDX_W),
    .FIRST_IDX(FIRST_FREE_IDX),
    .LAST_IDX (MATRIX_NUM - 1)
  ) u_alloc (
    .clk_i    (clk),
    .rst_i    (rst),
    .advance_i(advance),
    .idx_o    (next_idx)
  );

  always_comb begin
    buf_wr = buf_q;
    for (int unsigned k = 0; k < MEM_DEPTH; k++) begin
      if (cnt_q == CNT_W'(k)) buf_wr[k*DATA_WIDTH +: DATA_WIDTH] = elem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      err_code_q <= ERR_NONE;
      row_q      <= '0;
      col_q      <= '0;
      total_q    <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      buf_q      <= '0;
      flat_q     <= '0;
      tgt_q      <= '0;
      wrow_q     <= '0;
      wcol_q     <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            row_q   <= dim_row;
            col_q   <= dim_col;
            buf_q   <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
            state_q <= ST_CHECK;
            // Dimension check is pre-registered so the err pulse lands in the CHECK cycle.
            if (dims_bad(dim_row, dim_col, DIM_W'(MAX_SIZE))) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_DIM;
            end else begin
              err_code_q <= ERR_NONE;
            end
          end
        end
        ST_CHECK: begin
          total_q <= CNT_W'(row_q) * CNT_W'(col_q);
          if (dims_bad(row_q, col_q, DIM_W'(MAX_SIZE))) state_q <= ST_IDLE;
          else                                          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          if (cancel) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_CANCEL;
            state_q    <= ST_IDLE;
          end else if (elem_valid) begin
            buf_q  <= buf_wr;
            cnt_q  <= cnt_q + CNT_W'(1);
            idle_q <= '0;
            if (cnt_q == total_q - CNT_W'(1)) begin
              wr_en_q <= 1'b1;
              tgt_q   <= next_idx;
              wrow_q  <= row_q;
              wcol_q  <= col_q;
              flat_q  <= buf_wr;
              state_q <= ST_WRITE;
            end
          end else if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= ST_IDLE;
          end else begin
            idle_q <= idle_q + TW'(1);
          end
        end
        ST_WRITE: begin
          done_q  <= 1'b1;
          state_q <= ST_FIN;
        end
        ST_FIN:   state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign elem_ready = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_IDLE);
  assign wr_en      = wr_en_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign target_idx = tgt_q;
  assign write_row  = wrow_q;
  assign write_col  = wcol_q;
  assign data_flat  = flat_q;

endmodule

// File: tb/tb_matrix_write_ctrl.sv
// Directed bench for matrix_write_ctrl: writes, slot wrap, bad dims, timeout,
// cancel and reset abort, all against hand-computed values.
module tb_matrix_write_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cancel = 1'b0;
  logic          elem_valid = 1'b0;
  logic [2:0]    dim_row = '0;
  logic [2:0]    dim_col = '0;
  logic [DW-1:0] elem_data = '0;
  logic          elem_ready, wr_en, busy, done, err;
  logic [2:0]    target_idx, write_row, write_col;
  logic [1:0]    err_code;
  logic [25*DW-1:0] data_flat;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;

  matrix_write_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dim_row   (dim_row),
    .dim_col   (dim_col),
    .cancel    (cancel),
    .elem_valid(elem_valid),
    .elem_data (elem_data),
    .elem_ready(elem_ready),
    .wr_en     (wr_en),
    .target_idx(target_idx),
    .write_row (write_row),
    .write_col (write_col),
    .data_flat (data_flat),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) wr_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] lane(input int k);
    return data_flat[k*DW +: DW];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic do_start(input logic [2:0] r, input logic [2:0] c);
    start = 1'b1;
    dim_row = r;
    dim_col = c;
    tick();
    start = 1'b0;
  endtask

  // Feeds n elements base, base+1, ... one per handshake; cyc = ticks consumed.
  task automatic load(input int n, input logic [DW-1:0] base, output int cyc);
    int g;
    cyc = 0;
    elem_valid = 1'b1;
    elem_data = base;
    for (int i = 0; i < n; i++) begin
      g = 0;
      while (!elem_ready && g < 20) begin
        tick();
        cyc++;
        g++;
      end
      if (!elem_ready) begin
        chk("ready_wait", elem_ready, 1);
        break;
      end
      tick();
      cyc++;
      elem_data = 8'(base + i + 1);
    end
    elem_valid = 1'b0;
  endtask

  task automatic check_lanes(input string tag, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < 25; k++)
      chk($sformatf("%s_lane%0d", tag, k), lane(k), (k < n) ? 32'(8'(base + k)) : 32'd0);
  endtask

  task automatic write1x1(input string tag, input logic [DW-1:0] val, input logic [2:0] exp_idx);
    int cyc;
    do_start(3'd1, 3'd1);
    load(1, val, cyc);
    chk({tag, "_lat"}, cyc, 2);
    chk({tag, "_wr_en"}, wr_en, 1);
    chk({tag, "_idx"}, target_idx, exp_idx);
    chk({tag, "_lane0"}, lane(0), val);
    chk({tag, "_row"}, write_row, 1);
    chk({tag, "_col"}, write_col, 1);
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_wr_off"}, wr_en, 0);
    tick();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int cyc, w0, n;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", elem_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_idx", target_idx, 0);
    chk("rst_row", write_row, 0);
    chk("rst_flat", 32'(|data_flat), 0);
    rst = 1'b0;
    tick();

    // 1: 2x3 back-to-back load
    w0 = wr_cnt;
    do_start(3'd2, 3'd3);
    chk("t1_check_ready", elem_ready, 0);
    chk("t1_check_busy", busy, 1);
    load(6, 8'd1, cyc);
    chk("t1_lat", cyc, 7);
    chk("t1_wr_en", wr_en, 1);
    chk("t1_idx", target_idx, 4);
    chk("t1_row", write_row, 2);
    chk("t1_col", write_col, 3);
    check_lanes("t1", 6, 8'd1);
    tick();
    chk("t1_wr_off", wr_en, 0);
    chk("t1_done", done, 1);
    chk("t1_wr_count", wr_cnt - w0, 1);
    tick();
    chk("t1_done_off", done, 0);
    chk("t1_busy_off", busy, 0);

    // 2: slot wrap 4,5,6,7,4
    do_reset();
    write1x1("t2a", 8'hA0, 3'd4);
    write1x1("t2b", 8'hA1, 3'd5);
    write1x1("t2c", 8'hA2, 3'd6);
    write1x1("t2d", 8'hA3, 3'd7);
    write1x1("t2e", 8'hA4, 3'd4);

    // 3: bad dimensions
    w0 = wr_cnt;
    do_start(3'd0, 3'd3);
    chk("t3a_err", err, 1);
    chk("t3a_code", err_code, 1);
    chk("t3a_ready", elem_ready, 0);
    tick();
    chk("t3a_err_off", err, 0);
    chk("t3a_busy", busy, 0);
    chk("t3a_ready2", elem_ready, 0);
    chk("t3a_code_hold", err_code, 1);
    do_start(3'd6, 3'd2);
    chk("t3b_err", err, 1);
    chk("t3b_code", err_code, 1);
    tick();
    chk("t3b_busy", busy, 0);
    chk("t3b_ready", elem_ready, 0);
    chk("t3_no_wr", wr_cnt - w0, 0);
    write1x1("t3_next", 8'h77, 3'd5);

    // 4: timeout, then buffer is clean for the next write
    do_reset();
    w0 = wr_cnt;
    do_start(3'd2, 3'd2);
    load(2, 8'h11, cyc);
    n = 0;
    while (!err && n < 40) begin
      tick();
      n++;
    end
    chk("t4_idle_cycles", n, 16);
    chk("t4_code", err_code, 2);
    chk("t4_busy", busy, 0);
    chk("t4_no_wr", wr_cnt - w0, 0);
    tick();
    chk("t4_err_off", err, 0);
    write1x1("t4_next", 8'h5A, 3'd4);
    check_lanes("t4", 1, 8'h5A);

    // 5: start ignored in LOAD, cancel beats simultaneous handshake
    w0 = wr_cnt;
    do_start(3'd3, 3'd3);
    load(1, 8'h31, cyc);
    start = 1'b1;
    dim_row = 3'd1;
    dim_col = 3'd1;
    elem_valid = 1'b1;
    elem_data = 8'h32;
    tick();
    start = 1'b0;
    chk("t5_still_load", elem_ready, 1);
    chk("t5_busy", busy, 1);
    cancel = 1'b1;
    elem_data = 8'h33;
    tick();
    cancel = 1'b0;
    elem_valid = 1'b0;
    chk("t5_err", err, 1);
    chk("t5_code", err_code, 3);
    chk("t5_busy_off", busy, 0);
    chk("t5_ready_off", elem_ready, 0);
    tick();
    chk("t5_err_off", err, 0);
    chk("t5_code_hold", err_code, 3);
    chk("t5_no_wr", wr_cnt - w0, 0);
    write1x1("t5_next", 8'h99, 3'd5);

    // 6: reset during a 5x5 load
    w0 = wr_cnt;
    do_start(3'd5, 3'd5);
    load(3, 8'h51, cyc);
    rst = 1'b1;
    elem_valid = 1'b1;
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_ready", elem_ready, 0);
    chk("t6_err", err, 0);
    chk("t6_done", done, 0);
    chk("t6_code", err_code, 0);
    rst = 1'b0;
    elem_valid = 1'b0;
    repeat (3) tick();
    chk("t6_no_wr", wr_cnt - w0, 0);
    chk("t6_done_idle", done, 0);
    write1x1("t6_next", 8'h66, 3'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_write_ctrl.md
Name: matrix_write_ctrl

Overview:
Sequencer in front of multi_matrix_storage.
- Accepts a dimension command, then collects row*col elements one per valid/ready handshake into a 25-entry buffer.
- Issues a single-cycle wr_en burst to the storage with all 25 data lanes and the allocated target index.
- Allocates global indices round-robin over the non-preloaded slots.
- Reports done/error to the top-level UI FSM.

Parameters:
DATA_WIDTH, 8, element width
MAX_SIZE, 5, max rows/cols
MATRIX_NUM, 8, global storage slots
FIRST_FREE_IDX, 4, first slot not holding preloaded data; allocation range FIRST_FREE_IDX..MATRIX_NUM-1
TIMEOUT_CYC, 1000000, max idle cycles between elements in LOAD

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  command pulse, sampled only in IDLE
dim_row  in  3  requested rows, latched on accepted start
dim_col  in  3  requested cols, latched on accepted start
cancel  in  1  abort request, honoured in LOAD only
elem_valid  in  1  element available
elem_data  in  DATA_WIDTH  element, row-major order
elem_ready  out  1  high in LOAD
wr_en  out  1  storage write strobe, one cycle
target_idx  out  3  storage global index
write_row  out  3  latched rows
write_col  out  3  latched cols
data_flat  out  25*DATA_WIDTH  element k on bits [k*DW +: DW], drives storage data_in_k
busy  out  1  state != IDLE
done  out  1  one-cycle success pulse
err  out  1  one-cycle error pulse
err_code  out  2  0 none, 1 bad dimension, 2 timeout, 3 cancelled; held until next accepted start

Behaviour:
- Reset values: state IDLE; all outputs 0; buffer all 0; elem_cnt 0; idle counter 0; next_idx = FIRST_FREE_IDX.
- Reset mid-operation: abort immediately. No wr_en is issued, and no done/err pulse.
- FSM states: IDLE, CHECK, LOAD, WRITE, FIN.
- IDLE:
  - start=1 at edge k: latch dims, clear buffer to 0, clear elem_cnt and idle counter, clear err_code, go to CHECK.
  - start while busy is ignored.
- CHECK (cycle k+1):
  - If either dim is 0 or >MAX_SIZE: err=1 for that cycle, err_code=1, next state IDLE.
  - Otherwise compute total = row*col (5-bit, max 25) and go to LOAD.
- LOAD (elem_ready=1 from cycle k+2):
  - Handshake = elem_valid & elem_ready. On each handshake: buffer[elem_cnt] <= elem_data, elem_cnt++, idle counter cleared.
  - On the handshake where elem_cnt == total-1, go to WRITE.
  - cancel=1 in LOAD: err pulse, err_code=3, go to IDLE. Cancel wins over a simultaneous handshake, and that element is discarded.
  - Idle counter increments on cycles without a handshake. When it reaches TIMEOUT_CYC-1 with no handshake: err pulse, err_code=2, go to IDLE.
  - Cancel has priority over timeout.
- WRITE (cycle after last handshake):
  - wr_en=1 for exactly one cycle; target_idx=next_idx; write_row/col=latched dims; data_flat=buffer.
  - Positions >= total read 0.
  - Go to FIN.
- FIN:
  - done=1 for one cycle.
  - next_idx increments, wrapping MATRIX_NUM-1 -> FIRST_FREE_IDX.
  - Go to IDLE; busy low the following cycle.
- Error paths never change next_idx.
- target_idx, write_row/col and data_flat are registered. They hold their last values outside WRITE, and are valid only while wr_en=1.
- Latency: a 1x1 matrix gives start edge k -> wr_en at cycle k+3 (given elem_valid already high) -> done at k+4.

Decomposition:
- Shared package mat_pkg: DATA_WIDTH, MAX_SIZE, MATRIX_NUM, MEM_DEPTH=25, MATRIX_IDX_W=3, state encoding, err_code constants.
- One sub-module: mat_idx_alloc, the round-robin index counter with advance input and wrap range parameters.

Test Plan:
1. start, dims 2x3, elements 1..6 back-to-back -> elem_ready from cycle k+2, wr_en one cycle at k+8, target_idx=4, data_flat lanes 0..5 = 1..6, lanes 6..24 = 0, done next cycle.
2. Five successive 1x1 writes with values 0xA0..0xA4 -> target_idx sequence 4,5,6,7,4 (wrap check).
3. Dims 0x3, then 6x2 -> err pulse in CHECK, err_code=1, no wr_en, next_idx unchanged, elem_ready never high.
4. TIMEOUT_CYC=16, dims 2x2, two elements then stall -> err at 16th idle cycle, err_code=2, no wr_en. A following 1x1 write uses target_idx=4 and its lanes 1..24 = 0 (buffer cleared).
5. cancel asserted in the same cycle as the 3rd handshake of a 3x3 load -> err_code=3, no wr_en; start pulses during LOAD are ignored.
6. rst asserted mid-LOAD of 5x5 -> next cycle busy=0, elem_ready=0, wr_en never asserted, next_idx back to 4.
